ycchain_loader: RTL
===================

# ycchain_loader

Configuration sequencer for a chain of yellow cells. It accepts one 3-bit cell code per handshake from a host and serialises each code MSB-first onto the cell configuration shift chain, with a per-bit shift enable. It holds the asynchronous array in reset while the chain is being rewritten and releases reset after a programmable settle interval. It sits between the host/configuration port and the head of the cell chain, one instance per chain.

## Interface

Parameters:
- NCELLS, 16: yellow cells in the chain; range 1..1024.
- SETTLE, 4: cycles `array_reset` stays high after the last bit shifts; range 1..255.

Ports:
- confclk  input  1  configuration clock. Only clock in the block; all state is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a full-chain load.
- abort  input  1  cancels a load in progress.
- code_valid  input  1  host offers `code`.
- code  input  3  cell configuration code. The encoding is opaque to this block.
- code_ready  output  1  block accepts `code` this cycle.
- cbitout  output  1  serial bit to the chain head (the first cell's `cbitin`).
- cshift  output  1  chain shift enable. Integration gates `confclk` to the chain with it through a glitch-free clock gate.
- array_reset  output  1  drives `reset` of every cell FSM in the chain.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a load completes.
- configured  output  1  the chain holds a complete, non-aborted load.

## Operation

- States: IDLE, WAIT_CODE, SHIFT, SETTLE.
- **Registers:**
  - shreg[2:0]
  - bitcnt, 0..2
  - cellcnt, ceil(log2(NCELLS)) bits
  - setcnt, 8 bits
- **IDLE:**
  - `code_ready` = 0 and `cshift` = 0.
  - `array_reset` = ~configured.
  - `start` → WAIT_CODE. On entry: cellcnt = 0, configured = 0, array_reset = 1.
  - `code_valid` in IDLE is ignored; nothing is consumed.
- **WAIT_CODE:**
  - `code_ready` = 1.
  - On `code_valid & code_ready`: shreg = code, bitcnt = 0, go to SHIFT.
- **SHIFT:**
  - `cshift` = 1 and `cbitout` = shreg[2] for 3 cycles.
  - Each cycle: shreg = {shreg[1:0],0} and bitcnt increments.
  - On the bitcnt == 2 cycle:
    - If cellcnt == NCELLS-1 → SETTLE with setcnt = SETTLE-1.
    - Else cellcnt increments → WAIT_CODE.
- **SETTLE:**
  - `array_reset` = 1 and `cshift` = 0.
  - setcnt decrements each cycle.
  - At 0 → IDLE, `done` = 1 for that transition cycle, configured = 1.
- **Bit ordering:** the cell shifts toward its MSB, so code MSB goes first. After 3 shifts a cell holds the code exactly. The host sends the farthest cell's code first and the head cell's code last (NCELLS codes total).
- **abort** (any non-IDLE state):
  - Next state is IDLE, configured = 0, `array_reset` stays 1.
  - No `done` pulse.
  - If asserted the same cycle a code handshake would complete, abort wins and the code is not consumed (`code_ready` is forced 0 when `abort` = 1).
- `start` while busy is ignored.
- `start` and `abort` together in IDLE: abort wins, and the block stays IDLE.
- `cbitout` = 0 whenever `cshift` = 0.

## Timing

- **Reset values:**
  - State IDLE.
  - `code_ready` 0, `cbitout` 0, `cshift` 0, `busy` 0, `done` 0, `configured` 0.
  - `array_reset` 1 (unconfigured array held in reset).
- All outputs are registered, or decoded from registered state only. No combinational path from `code_valid` to any output.
- **Per-cell cadence:**
  - Handshake in cycle N.
  - `cshift` high in N+1..N+3.
  - `code_ready` high again from N+4.
  - Throughput is 4 cycles per cell when the host is never stalled.
- **Minimum load time:** start in cycle S, code_valid held high → `done` in cycle S + 1 + 4·NCELLS + SETTLE.
- **Host stalls:** `code_valid` low in WAIT_CODE simply holds the state. There is no timeout.
- `array_reset` falls the cycle after `done`, stays low until the next `start`/`abort`, and rises the cycle after `start` is sampled.

## Test plan

- **Single load, NCELLS=2, SETTLE=4:**
  - Stimulus: reset, then start, then codes 3'b110 and 3'b001 back-to-back.
  - `cbitout` sequence under `cshift` is 1,1,0,0,0,1.
  - `done` is high exactly 13 cycles after start.
  - configured = 1 and `array_reset` falls the next cycle.
- **Host stall:** `code_valid` low for 7 cycles between cells → `cshift` stays 0 and `code_ready` stays 1 throughout; total load time extends by exactly 7.
- **Abort mid-SHIFT:** abort on the 2nd shift bit of cell 1 → next cycle IDLE, `cshift` 0, no `done`, configured 0, `array_reset` 1.
- **Ignored inputs:** `start` pulsed during SHIFT and `code_valid` pulsed in IDLE → no state change and no extra handshake accepted.
- **Async reset during SETTLE:** all outputs return to reset values immediately without a clock edge; `array_reset` = 1.
- **Reload:** second load after a completed one → `array_reset` rises the cycle after start; configured drops to 0 until the new `done`.

Source files
------------

// File: rtl/ycchain_loader.sv
// ycchain_loader: serialises 3-bit yellow-cell codes onto the cell
// configuration chain and holds the array in reset while it is rewritten.
//
// Ports:
//   confclk      configuration clock (rising edge)
//   reset        async active-high reset
//   start        begin a full-chain load (ignored while busy)
//   abort        cancel a load in progress
//   code_valid   host offers code
//   code[2:0]    cell code, sent MSB first
//   code_ready   block accepts code this cycle
//   cbitout      serial bit to the chain head
//   cshift       chain shift enable
//   array_reset  reset for every cell FSM in the chain
//   busy         not idle
//   done         one-cycle pulse when a load completes
//   configured   chain holds a complete, non-aborted load
module ycchain_loader #(
  parameter int NCELLS = 16,
  parameter int SETTLE = 4
) (
  input  logic       confclk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       code_valid,
  input  logic [2:0] code,
  output logic       code_ready,
  output logic       cbitout,
  output logic       cshift,
  output logic       array_reset,
  output logic       busy,
  output logic       done,
  output logic       configured
);

  localparam int CW = (NCELLS > 1) ? $clog2(NCELLS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCELLS - 1);
  localparam logic [7:0] SET0 = 8'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_SETTLE
  } state_t;

  state_t state;
  state_t nstate;

  logic [2:0]    shreg;
  logic [1:0]    bitcnt;
  logic [CW-1:0] cellcnt;
  logic [7:0]    setcnt;
  logic          cfg_q;
  logic          done_q;
  logic          arst_q;

  logic go;
  logic take;
  logic last_bit;
  logic last_cell;
  logic settle_end;
  logic in_idle;

  assign in_idle    = (state == S_IDLE);
  assign go         = in_idle & start & ~abort;
  assign take       = (state == S_WAIT) & code_valid & ~abort;
  assign last_bit   = (bitcnt == 2'd2);
  assign last_cell  = (cellcnt == LAST);
  assign settle_end = (setcnt == 8'd0);

  // State register
  always_ff @(posedge confclk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= nstate;
    end
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE: begin
        if (go) nstate = S_WAIT;
      end
      S_WAIT: begin
        if (abort)           nstate = S_IDLE;
        else if (code_valid) nstate = S_SHIFT;
      end
      S_SHIFT: begin
        if (abort)
          nstate = S_IDLE;
        else if (last_bit)
          nstate = last_cell ? S_SETTLE : S_WAIT;
      end
      S_SETTLE: begin
        if (abort || settle_end) nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  // Datapath and registered status
  always_ff @(posedge confclk or posedge reset) begin
    if (reset) begin
      shreg   <= 3'd0;
      bitcnt  <= 2'd0;
      cellcnt <= '0;
      setcnt  <= 8'd0;
      cfg_q   <= 1'b0;
      done_q  <= 1'b0;
      arst_q  <= 1'b1;
    end else begin
      done_q <= (state == S_SETTLE) & settle_end & ~abort;
      // Release the array only once idle with a good load, i.e. the
      // cycle after done; re-assert as soon as a new load is taken.
      arst_q <= ~(in_idle & cfg_q & ~go);

      if (go || (abort && !in_idle))
        cfg_q <= 1'b0;
      else if ((state == S_SETTLE) && settle_end)
        cfg_q <= 1'b1;

      if (go) cellcnt <= '0;

      if (take) begin
        shreg  <= code;
        bitcnt <= 2'd0;
      end

      if (state == S_SHIFT) begin
        shreg  <= {shreg[1:0], 1'b0};
        bitcnt <= last_bit ? 2'd0 : bitcnt + 2'd1;
        if (last_bit && !last_cell)
          cellcnt <= cellcnt + 1'b1;
        if (last_bit)
          setcnt <= SET0;
      end

      if ((state == S_SETTLE) && !settle_end)
        setcnt <= setcnt - 8'd1;
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    busy        = ~in_idle;
    cshift      = (state == S_SHIFT);
    cbitout     = (state == S_SHIFT) & shreg[2];
    code_ready  = (state == S_WAIT) & ~abort;
    done        = done_q;
    configured  = cfg_q;
    array_reset = arst_q;
  end

endmodule
